// File: rtl/div_mod_pkg.sv
// Shared types for the streaming divisibility checker: FSM encoding
// and a width helper that never returns zero.
package div_mod_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/div_mod_stream_if.sv
// Digit-in / result-out handshake bundle for div_mod_stream.
// master drives digits and out_ready; slave is the checker.
interface div_mod_stream_if #(
  parameter int DIGIT_W = 4,
  parameter int REM_W   = 4,
  parameter int CNT_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic               out_divisible;
  logic [REM_W-1:0]   out_remainder;
  logic [CNT_W-1:0]   out_count;
  logic               out_error;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_divisible,
    input  out_remainder, out_count, out_error
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_divisible,
    output out_remainder, out_count, out_error
  );
endinterface

// File: rtl/mod_step.sv
// One Horner step: nxt = (rem*RADIX + d) mod MODULUS, single cycle.
// Ports: rem/digit in, nxt out, bad flags digit >= RADIX (d forced 0).
module mod_step
  import div_mod_pkg::*;
#(
  parameter int MODULUS = 11,
  parameter int RADIX   = 10,
  parameter int DIGIT_W = 4,
  localparam int REM_W  = clog2w(MODULUS)
) (
  input  logic [REM_W-1:0]   rem,
  input  logic [DIGIT_W-1:0] digit,
  output logic [REM_W-1:0]   nxt,
  output logic               bad
);
  // widest sum is MODULUS*RADIX-1
  localparam int SUM_W = clog2w(MODULUS * RADIX);
  localparam logic [DIGIT_W:0] RAD = (DIGIT_W+1)'(RADIX);

  logic [DIGIT_W-1:0] d;
  logic [SUM_W-1:0]   sum;

  always_comb begin
    bad = ({1'b0, digit} >= RAD);
    d   = bad ? '0 : digit;
    sum = SUM_W'(rem) * SUM_W'(RADIX) + SUM_W'(d);
    nxt = REM_W'(sum % SUM_W'(MODULUS));
  end
endmodule

// File: rtl/div_mod_stream.sv
// Streams MSB-first digits and reports number mod MODULUS on a held result.
// Ports: clk, rst (async high), bus (slave modport of div_mod_stream_if).
module div_mod_stream
  import div_mod_pkg::*;
#(
  parameter int MODULUS    = 11,
  parameter int RADIX      = 10,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 16,
  localparam int REM_W     = clog2w(MODULUS),
  localparam int CNT_W     = clog2w(MAX_DIGITS + 1)
) (
  input logic              clk,
  input logic              rst,
  div_mod_stream_if.slave  bus
);
  if (MODULUS < 2 || RADIX < 2 || RADIX > (1 << DIGIT_W)) begin : g_bad
    $error("div_mod_stream: illegal MODULUS/RADIX/DIGIT_W");
  end

  state_t           state;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             div_q;
  logic             rdy_q;
  logic             vld_q;

  logic [REM_W-1:0] nxt_rem;
  logic             bad;
  logic             acc;
  logic             at_max;
  logic             term;
  logic             nxt_err;

  mod_step #(
    .MODULUS (MODULUS),
    .RADIX   (RADIX),
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .rem   (rem),
    .digit (bus.in_digit),
    .nxt   (nxt_rem),
    .bad   (bad)
  );

  always_comb begin
    acc     = bus.in_valid & rdy_q;
    at_max  = (cnt == CNT_W'(MAX_DIGITS - 1));
    term    = bus.in_last | at_max;
    // count-limit termination without last is an overrun
    nxt_err = err | bad | (at_max & ~bus.in_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      rem   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      div_q <= 1'b0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          rdy_q <= 1'b1;
          if (acc) begin
            rem <= nxt_rem;
            cnt <= cnt + 1'b1;
            err <= nxt_err;
            if (term) begin
              state <= RESULT;
              rdy_q <= 1'b0;
              vld_q <= 1'b1;
              div_q <= (nxt_rem == '0) & ~nxt_err;
            end
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            state <= ACCUM;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
            rem   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            div_q <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.out_valid     = vld_q;
  assign bus.out_divisible = div_q;
  assign bus.out_remainder = rem;
  assign bus.out_count     = cnt;
  assign bus.out_error     = err;
endmodule

// File: tb/tb_div_mod_stream.sv
// Self-checking bench for div_mod_stream: arithmetic model plus
// directed numbers, one default instance and one MODULUS=7/RADIX=16.
module tb_div_mod_stream;

  typedef struct {
    int rem;
    int cnt;
    bit err;
    bit dv;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  res_t expq[$];
  res_t e;

  longint unsigned mval = 0;
  int              mcnt = 0;
  bit              merr = 1'b0;

  div_mod_stream_if #(.DIGIT_W(4), .REM_W(4), .CNT_W(5)) ifa ();
  div_mod_stream_if #(.DIGIT_W(4), .REM_W(3), .CNT_W(5)) ifb ();

  div_mod_stream dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  div_mod_stream #(.MODULUS(7), .RADIX(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // per-cycle compare of instance A against the model queue
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_in_ready", ifa.in_ready, 0);
      chk("rst_divisible", ifa.out_divisible, 0);
      chk("rst_remainder", ifa.out_remainder, 0);
      chk("rst_count", ifa.out_count, 0);
      chk("rst_error", ifa.out_error, 0);
    end else if (ifa.out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = expq[0];
        chk("cmp_remainder", ifa.out_remainder, e.rem);
        chk("cmp_count", ifa.out_count, e.cnt);
        chk("cmp_error", ifa.out_error, e.err);
        chk("cmp_divisible", ifa.out_divisible, e.dv);
        chk("cmp_in_ready_low", ifa.in_ready, 0);
        if (ifa.out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic model_clear();
    mval = 0;
    mcnt = 0;
    merr = 1'b0;
  endtask

  task automatic put_a(input logic [3:0] d, input bit last);
    int   t = 0;
    bit   term;
    res_t r;
    ifa.in_valid = 1'b1;
    ifa.in_digit = d;
    ifa.in_last  = last;
    while (!ifa.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ifa.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      ifa.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
    if (d >= 10) merr = 1'b1;
    mval = mval * 10 + ((d >= 10) ? 0 : d);
    mcnt++;
    term = last || (mcnt == 16);
    if (!last && mcnt == 16) merr = 1'b1;
    if (term) begin
      r.rem = int'(mval % 11);
      r.cnt = mcnt;
      r.err = merr;
      r.dv  = (r.rem == 0) && !merr;
      expq.push_back(r);
      model_clear();
    end
    chk("latency_out_valid", ifa.out_valid, term);
  endtask

  task automatic take_a(input int stall, input int lrem,
                        input int lcnt, input bit lerr, input bit ldv);
    int t = 0;
    while (!ifa.out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ifa.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("lit_remainder", ifa.out_remainder, lrem);
    chk("lit_count", ifa.out_count, lcnt);
    chk("lit_error", ifa.out_error, lerr);
    chk("lit_divisible", ifa.out_divisible, ldv);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (stall > 0) begin
      chk("held_valid", ifa.out_valid, 1);
      chk("held_in_ready", ifa.in_ready, 0);
      chk("held_remainder", ifa.out_remainder, lrem);
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    chk("released_valid", ifa.out_valid, 0);
    chk("released_in_ready", ifa.in_ready, 1);
  endtask

  task automatic put_b(input logic [3:0] d, input bit last);
    int t = 0;
    ifb.in_valid = 1'b1;
    ifb.in_digit = d;
    ifb.in_last  = last;
    while (!ifb.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ifb.in_ready) chk("b_in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    ifb.in_last  = 1'b0;
  endtask

  task automatic take_b(input int lrem, input int lcnt, input bit ldv);
    chk("b_out_valid", ifb.out_valid, 1);
    chk("b_remainder", ifb.out_remainder, lrem);
    chk("b_count", ifb.out_count, lcnt);
    chk("b_error", ifb.out_error, 0);
    chk("b_divisible", ifb.out_divisible, ldv);
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    ifb.out_ready = 1'b0;
    chk("b_released", ifb.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.in_digit = '0;
    ifa.in_last = 1'b0;  ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_digit = '0;
    ifb.in_last = 1'b0;  ifb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", ifa.in_ready, 0);
    chk("reset_out_valid", ifa.out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", ifa.in_ready, 1);

    put_a(1, 0); put_a(2, 0); put_a(1, 1);
    take_a(0, 0, 3, 0, 1);

    put_a(1, 0); put_a(2, 0); put_a(3, 0); put_a(4, 1);
    take_a(0, 2, 4, 0, 0);

    put_a(5, 0); put_a(12, 0); put_a(3, 1);
    take_a(0, 8, 3, 1, 0);

    put_a(9, 0); put_a(9, 1);
    take_a(5, 0, 2, 0, 1);
    put_a(7, 0); put_a(7, 1);
    take_a(0, 0, 2, 0, 1);

    put_a(3, 0); put_a(4, 0);
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_valid", ifa.out_valid, 0);
    chk("midrst_count", ifa.out_count, 0);
    chk("midrst_remainder", ifa.out_remainder, 0);
    chk("midrst_in_ready", ifa.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_result_after_rst", ifa.out_valid, 0);
    put_a(2, 0); put_a(2, 1);
    take_a(0, 0, 2, 0, 1);

    for (int i = 0; i < 16; i++) put_a(1, 0);
    take_a(0, 0, 16, 1, 0);

    for (int i = 0; i < 15; i++) put_a(0, 0);
    put_a(5, 1);
    take_a(0, 5, 16, 0, 0);

    put_b(1, 0); put_b(4'hC, 1);
    take_b(0, 2, 1);
    put_b(1, 0); put_b(4'hD, 1);
    take_b(1, 2, 0);

    repeat (2) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
